regfile_wb_arbiter: RTL

//  Shares the register file's single write port (we3/wa3/wd3) between two writeback

---
 rtl/regfile_wb_arbiter_pkg.sv | 30 +++
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int BANK_WIDTH_DEF = 5;
    localparam int WIDTH_DEF      = 64;
    localparam int CNT_WIDTH_DEF  = 16;

    // Writeback source; the value doubles as the request/grant bit index.
    typedef enum logic {
        SRC_EX  = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic [BANK_WIDTH_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0]      data;
    } wb_req_t;

    // The requester that should win a tie, given who won last.
    function automatic wb_src_e other_src(input wb_src_e src);
        wb_src_e res;
        case (src)
            SRC_EX:  res = SRC_MEM;
            SRC_MEM: res = SRC_EX;
            default: res = SRC_EX;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the EX/MEM writeback requesters, the regfile write port
// and the forward query ports.
interface regfile_wb_arbiter_if #(
    parameter int BANK_WIDTH = 5,
    parameter int WIDTH      = 64,
    parameter int CNT_WIDTH  = 16
);
    logic                  ex_valid;
    logic                  ex_ready;
    logic [BANK_WIDTH-1:0] ex_addr;
    logic [WIDTH-1:0]      ex_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [BANK_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_data;
    logic                  rf_we3;
    logic [BANK_WIDTH-1:0] rf_wa3;
    logic [WIDTH-1:0]      rf_wd3;
    logic [BANK_WIDTH-1:0] q_ra1;
    logic [BANK_WIDTH-1:0] q_ra2;
    logic                  fwd_hit1;
    logic                  fwd_hit2;
    logic [WIDTH-1:0]      fwd_data;
    logic [CNT_WIDTH-1:0]  contention;

    modport slave (
        input  ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data, q_ra1, q_ra2,
        output ex_ready, mem_ready, rf_we3, rf_wa3, rf_wd3, fwd_hit1, fwd_hit2, fwd_data,
               contention
    );

    modport master (
        output ex_valid, ex_addr, ex_data, mem_valid, mem_addr, mem_data, q_ra1, q_ra2,
        input  ex_ready, mem_ready, rf_we3, rf_wa3, rf_wd3, fwd_hit1, fwd_hit2, fwd_data,
               contention
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=EX, req[1]=MEM. On a tie the requester
// that did not win last time is granted. Grants are forced off during reset.
module regfile_wb_arbiter_rr_arb2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    wb_src_e    last_grant_r;
    logic [1:0] gnt_s;

    // Pick the winner from the request vector and the last-grant history.
    always_comb begin
        gnt_s = 2'b00;
        case (req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11: begin
                if (other_src(last_grant_r) == SRC_EX) begin
                    gnt_s = 2'b01;
                end else begin
                    gnt_s = 2'b10;
                end
            end
            default: gnt_s = 2'b00;
        endcase
    end

    assign gnt = reset ? 2'b00 : gnt_s;

    // Remember who won the most recent handshake; MEM after reset so EX wins first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= SRC_MEM;
        end else if (gnt_s[0]) begin
            last_grant_r <= SRC_EX;
        end else if (gnt_s[1]) begin
            last_grant_r <= SRC_MEM;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between EX and MEM writeback, stages the winner
// for one cycle, forwards the staged write and counts contention cycles.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int BANK_WIDTH = BANK_WIDTH_DEF,
    parameter int WIDTH      = WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
)(
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);
    logic [1:0]            gnt_s;
    logic                  hs_s;
    logic                  both_s;
    logic [BANK_WIDTH-1:0] win_addr_s;
    logic [WIDTH-1:0]      win_data_s;
    logic                  rf_we3_r;
    logic [BANK_WIDTH-1:0] rf_wa3_r;
    logic [WIDTH-1:0]      rf_wd3_r;
    logic [CNT_WIDTH-1:0]  cnt_r;

    regfile_wb_arbiter_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.mem_valid, bus.ex_valid}),
        .gnt   (gnt_s)
    );

    // A grant only exists with a valid request, so a grant is a handshake.
    assign hs_s   = |gnt_s;
    assign both_s = bus.ex_valid & bus.mem_valid;

    // Route the winning requester's address and data to the stage.
    always_comb begin
        win_addr_s = bus.ex_addr;
        win_data_s = bus.ex_data;
        if (gnt_s[1]) begin
            win_addr_s = bus.mem_addr;
            win_data_s = bus.mem_data;
        end else begin
            win_addr_s = bus.ex_addr;
            win_data_s = bus.ex_data;
        end
    end

    // Output stage: the enable already folds in the x0 suppression.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we3_r <= 1'b0;
            rf_wa3_r <= {BANK_WIDTH{1'b0}};
            rf_wd3_r <= {WIDTH{1'b0}};
        end else if (hs_s) begin
            rf_we3_r <= (win_addr_s != {BANK_WIDTH{1'b0}});
            rf_wa3_r <= win_addr_s;
            rf_wd3_r <= win_data_s;
        end else begin
            rf_we3_r <= 1'b0;
            rf_wa3_r <= rf_wa3_r;
            rf_wd3_r <= rf_wd3_r;
        end
    end

    // Saturating count of cycles in which both requesters are valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (both_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.ex_ready   = gnt_s[0];
    assign bus.mem_ready  = gnt_s[1];
    assign bus.rf_we3     = rf_we3_r;
    assign bus.rf_wa3     = rf_wa3_r;
    assign bus.rf_wd3     = rf_wd3_r;
    assign bus.fwd_hit1   = rf_we3_r & (rf_wa3_r == bus.q_ra1);
    assign bus.fwd_hit2   = rf_we3_r & (rf_wa3_r == bus.q_ra2);
    assign bus.fwd_data   = rf_wd3_r;
    assign bus.contention = cnt_r;

endmodule
